// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES tables (forward/inverse S-box, Rcon), round-count
//                helper and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Controller states of the iterative inverse cipher
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } aesState_t;

    // Forward S-box, entry 0 is the leftmost byte
    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 is the leftmost byte
    localparam logic [0:255][7:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Round constants; index i holds Rcon[i] (index 0 and 11..15 unused)
    localparam logic [0:15][7:0] C_RCON = 128'h0001020408102040801b360000000000;

    // Number of rounds for a given key length
    function automatic int nrOf(input int keyBits);
        return keyBits / 32 + 6;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return C_SBOX[x];
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return C_INV_SBOX[x];
    endfunction

    function automatic logic [7:0] rconByte(input logic [3:0] idx);
        return C_RCON[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sched
//  Description : Sequential AES key expansion, one schedule word per cycle,
//                with round-key storage and a 128-bit round-key read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched #(
    parameter int KEY_BITS = 128
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] secret,
    input  logic [3:0]          rdIdx,
    output logic                done,
    output logic [127:0]        roundKey
);
    import aes_pkg::*;

    localparam int NK = KEY_BITS / 32;
    localparam int NR = nrOf(KEY_BITS);
    localparam int NW = 4 * (NR + 1);

    // Schedule storage; no reset, it is always rewritten before first use
    logic [31:0] r_words [NW];

    logic        r_busy;
    logic [5:0]  r_idx;      // index of the word being generated
    logic [2:0]  r_kmod;     // r_idx mod NK, tracked incrementally
    logic [3:0]  r_rconIdx;  // r_idx / NK, used when r_kmod wraps to 0

    logic [31:0] w_prevWord;
    logic [31:0] w_backWord;
    logic [31:0] w_temp;
    logic [31:0] w_newWord;
    logic [5:0]  w_base;

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign w_prevWord = r_words[r_idx - 6'd1];
    assign w_backWord = r_words[r_idx - 6'(NK)];

    // Next schedule word: w[i] = w[i-NK] ^ f(w[i-1])
    always_comb begin
        w_temp = w_prevWord;
        if (r_kmod == 3'd0) begin
            w_temp = subWord({w_prevWord[23:0], w_prevWord[31:24]})
                   ^ {rconByte(r_rconIdx), 24'h000000};
        end else if ((NK > 6) && (r_kmod == 3'd4)) begin
            w_temp = subWord(w_prevWord);
        end
        w_newWord = w_backWord ^ w_temp;
    end

    // Expansion sequencing: load on start, then step until the last word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_kmod    <= '0;
            r_rconIdx <= '0;
        end else if (start) begin
            r_busy    <= 1'b1;
            r_idx     <= 6'(NK);
            r_kmod    <= '0;
            r_rconIdx <= 4'd1;
        end else if (r_busy) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'(NW - 1)) begin
                r_busy <= 1'b0;
            end
            if (r_kmod == 3'(NK - 1)) begin
                r_kmod    <= '0;
                r_rconIdx <= r_rconIdx + 4'd1;
            end else begin
                r_kmod <= r_kmod + 3'd1;
            end
        end
    end

    // Word storage: the secret fills w[0..NK-1], generated words follow
    always_ff @(posedge clock) begin
        if (start) begin
            for (int k = 0; k < NK; k++) begin
                r_words[k] <= secret[KEY_BITS-1-32*k -: 32];
            end
        end else if (r_busy) begin
            r_words[r_idx] <= w_newWord;
        end
    end

    assign done     = r_busy && (r_idx == 6'(NW - 1));
    assign w_base   = {rdIdx, 2'b00};
    assign roundKey = {r_words[w_base], r_words[w_base + 6'd1],
                       r_words[w_base + 6'd2], r_words[w_base + 6'd3]};

endmodule
`default_nettype wire

// File: rtl/aes_inv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_iter
//  Description : Iterative AES-128/192/256 decryption, one round per cycle,
//                with an on-demand cached key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                key_new,
    input  logic [KEY_BITS-1:0] secret,
    input  logic [127:0]        cipher,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        plaintext
);
    import aes_pkg::*;

    localparam int NR = nrOf(KEY_BITS);

    aesState_t    r_state;
    aesState_t    w_stateNext;
    logic [127:0] r_blk;
    logic [127:0] r_plain;
    logic         r_outValid;
    logic         r_keyOk;
    logic [3:0]   r_round;

    logic         w_accept;
    logic         w_needExp;
    logic         w_schedStart;
    logic         w_schedDone;
    logic [3:0]   w_rdIdx;
    logic [127:0] w_roundKey;
    logic [127:0] w_lastRound;

    // GF(2^8) multiply by a 4-bit constant (covers 9, b, d, e)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
        x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
        return (m[3] ? x8 : 8'h00) ^ (m[2] ? x4 : 8'h00)
             ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? a : 8'h00);
    endfunction

    // Row r rotates right by r columns
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127-8*k -: 8] = invSbox(s[127-8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    assign in_ready     = (r_state == IDLE);
    assign w_accept     = in_valid & in_ready;
    // An invalid cached schedule forces expansion regardless of key_new
    assign w_needExp    = key_new | ~r_keyOk;
    assign w_schedStart = w_accept & w_needExp;
    assign w_rdIdx      = (r_state == INIT) ? 4'(NR) : r_round;
    // Round body shared by the middle rounds and the final round
    assign w_lastRound  = invSubBytes(invShiftRows(r_blk)) ^ w_roundKey;

    aes_key_sched #(
        .KEY_BITS (KEY_BITS)
    ) u_keySched (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (w_schedStart),
        .secret   (secret),
        .rdIdx    (w_rdIdx),
        .done     (w_schedDone),
        .roundKey (w_roundKey)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = w_needExp ? KEXP : INIT;
            KEXP:    if (w_schedDone) w_stateNext = INIT;
            INIT:    w_stateNext = ROUND;
            ROUND:   if (r_round == 4'd0) w_stateNext = DONE;
            DONE:    if (out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Block datapath, round counter, key validity and output handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blk      <= '0;
            r_plain    <= '0;
            r_outValid <= 1'b0;
            r_keyOk    <= 1'b0;
            r_round    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_blk <= cipher;
                        if (w_needExp) begin
                            r_keyOk <= 1'b0;
                        end
                    end
                end
                KEXP: begin
                    if (w_schedDone) begin
                        r_keyOk <= 1'b1;
                    end
                end
                INIT: begin
                    r_blk   <= r_blk ^ w_roundKey;
                    r_round <= 4'(NR - 1);
                end
                ROUND: begin
                    if (r_round == 4'd0) begin
                        r_plain    <= w_lastRound;
                        r_outValid <= 1'b1;
                    end else begin
                        r_blk   <= invMixColumns(w_lastRound);
                        r_round <= r_round - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign plaintext = r_plain;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_iter
//  Description : Directed self-checking bench for aes_inv_iter using the
//                FIPS-197 example vectors at all three key sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_iter;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   inValid = 3'b000;
    logic         keyNew = 1'b0;
    logic         outReady = 1'b1;
    logic [127:0] secret128 = '0;
    logic [191:0] secret192 = '0;
    logic [255:0] secret256 = '0;
    logic [127:0] cipherIn = '0;
    logic [2:0]   inReady;
    logic [2:0]   outValid;
    logic [127:0] plain0;
    logic [127:0] plain1;
    logic [127:0] plain2;

    int nTests = 0;
    int nFail  = 0;

    always #5 clock = ~clock;

    aes_inv_iter #(.KEY_BITS(128)) u_dut128 (
        .clock(clock), .reset_n(reset_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .key_new(keyNew), .secret(secret128), .cipher(cipherIn),
        .out_valid(outValid[0]), .out_ready(outReady), .plaintext(plain0));

    aes_inv_iter #(.KEY_BITS(192)) u_dut192 (
        .clock(clock), .reset_n(reset_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .key_new(keyNew), .secret(secret192), .cipher(cipherIn),
        .out_valid(outValid[1]), .out_ready(outReady), .plaintext(plain1));

    aes_inv_iter #(.KEY_BITS(256)) u_dut256 (
        .clock(clock), .reset_n(reset_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .key_new(keyNew), .secret(secret256), .cipher(cipherIn),
        .out_valid(outValid[2]), .out_ready(outReady), .plaintext(plain2));

    function automatic logic [127:0] plainOf(input int sel);
        return (sel == 0) ? plain0 : (sel == 1) ? plain1 : plain2;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input int sel, input logic kn, input logic [127:0] ct, input logic [255:0] key);
        @(negedge clock);
        check("ready_before_offer", {127'd0, inReady[sel]}, 128'd1);
        keyNew    = kn;
        cipherIn  = ct;
        secret128 = key[255:128];
        secret192 = key[255:64];
        secret256 = key;
        inValid[sel] = 1'b1;
        @(posedge clock);
        #1;
        inValid = 3'b000;
    endtask

    task automatic waitOut(input int sel, input logic [127:0] expPt, input int expLat,
                           input string tag, input bit scramble);
        int lat;
        lat = 0;
        while (outValid[sel] !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (scramble) begin
                cipherIn  = {$urandom(), $urandom(), $urandom(), $urandom()};
                secret128 = {$urandom(), $urandom(), $urandom(), $urandom()};
                secret192 = {secret128, $urandom(), $urandom()};
                secret256 = {secret128, secret128};
                keyNew    = 1'($urandom_range(0, 1));
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(expLat));
        check({tag, "_plaintext"}, plainOf(sel), expPt);
    endtask

    task automatic drain(input int sel, input logic [127:0] expPt, input string tag);
        @(posedge clock);
        #1;
        check({tag, "_valid_low"}, {127'd0, outValid[sel]}, 128'd0);
        check({tag, "_ready_back"}, {127'd0, inReady[sel]}, 128'd1);
        check({tag, "_pt_retained"}, plainOf(sel), expPt);
    endtask

    task automatic pulseResetCheck(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, "_out_valid"}, {127'd0, outValid[0]}, 128'd0);
        check({tag, "_plaintext"}, plain0, 128'd0);
        check({tag, "_in_ready"}, {127'd0, inReady[0]}, 128'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "_ready_after"}, {127'd0, inReady[0]}, 128'd1);
        check({tag, "_no_output"}, {127'd0, outValid[0]}, 128'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", {125'd0, outValid}, 128'd0);
        check("reset_plaintext", plain0, 128'd0);
        check("reset_in_ready", {125'd0, inReady}, 128'd7);
        @(negedge clock);
        reset_n = 1'b1;

        // First request after reset with key_new=0 must still expand
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 51, "aes128_forced", 1'b0);
        drain(0, PT, "aes128_forced");

        // Cached schedule
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 11, "aes128_cached", 1'b0);
        drain(0, PT, "aes128_cached");

        // New key while a valid one is cached, inputs scrambled mid-operation
        offer(0, 1'b1, CTB, KB);
        waitOut(0, PTB, 51, "aes128_newkey", 1'b1);
        drain(0, PTB, "aes128_newkey");

        // Cached new key; secret presented here must be ignored
        offer(0, 1'b0, CTB, 256'd0);
        waitOut(0, PTB, 11, "aes128_keyB_cached", 1'b0);
        drain(0, PTB, "aes128_keyB_cached");

        // Back to the original key
        offer(0, 1'b1, CT128, K128);
        waitOut(0, PT, 51, "aes128_rekey", 1'b0);
        drain(0, PT, "aes128_rekey");

        // AES-192 and AES-256
        offer(1, 1'b1, CT192, K192);
        waitOut(1, PT, 59, "aes192", 1'b1);
        drain(1, PT, "aes192");
        offer(2, 1'b1, CT256, K256);
        waitOut(2, PT, 67, "aes256", 1'b1);
        drain(2, PT, "aes256");
        offer(2, 1'b0, CT256, K256);
        waitOut(2, PT, 15, "aes256_cached", 1'b0);
        drain(2, PT, "aes256_cached");

        // Back-pressure in DONE with inputs toggling
        outReady = 1'b0;
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 11, "stall", 1'b0);
        for (int i = 0; i < 20; i++) begin
            cipherIn   = {$urandom(), $urandom(), $urandom(), $urandom()};
            secret128  = {$urandom(), $urandom(), $urandom(), $urandom()};
            keyNew     = 1'($urandom_range(0, 1));
            inValid[0] = 1'b1;
            @(posedge clock);
            #1;
            check("stall_out_valid", {127'd0, outValid[0]}, 128'd1);
            check("stall_in_ready", {127'd0, inReady[0]}, 128'd0);
            check("stall_plaintext", plain0, PT);
        end
        inValid  = 3'b000;
        keyNew   = 1'b0;
        outReady = 1'b1;
        drain(0, PT, "stall_release");
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 11, "after_stall", 1'b0);
        drain(0, PT, "after_stall");

        // Reset during cycle 20 of key expansion
        offer(0, 1'b1, CT128, K128);
        repeat (19) @(posedge clock);
        pulseResetCheck("rst_kexp");
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 51, "rst_kexp_recover", 1'b0);
        drain(0, PT, "rst_kexp_recover");

        // Reset in the middle of the rounds
        offer(0, 1'b0, CT128, K128);
        repeat (6) @(posedge clock);
        pulseResetCheck("rst_round");
        offer(0, 1'b0, CT128, K128);
        waitOut(0, PT, 51, "rst_round_recover", 1'b0);
        drain(0, PT, "rst_round_recover");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
